// File: rtl/fisr_seed_gen.sv
// Seed generator for the fast inverse square root Newton stage: classifies x, emits x/2 and MAGIC-(x>>1).
// Two register stages. Defining FISR_SEED_STATS_EN adds the Special_cnt/Stats_clr statistics ports.
module fisr_seed_gen #(
    parameter logic [31:0] MAGIC = 32'h5F3759DF,
    parameter int          TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             In_valid,
    input  logic [31:0]      Data_in,
    input  logic [TAG_W-1:0] Tag_in,
`ifdef FISR_SEED_STATS_EN
    input  logic             Stats_clr,
    output logic [15:0]      Special_cnt,
`endif
    output logic [31:0]      X_half,
    output logic [31:0]      Y_seed,
    output logic [2:0]       Special,
    output logic [TAG_W-1:0] Tag_out,
    output logic             Valid
);

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'b000,
        CLS_ZERO   = 3'b001,
        CLS_NEG    = 3'b010,
        CLS_PINF   = 3'b011,
        CLS_NAN    = 3'b100
    } class_e;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_data_q,  s1_data_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    class_e           s1_class_q, s1_class_d;

    logic             valid_q,   valid_d;
    logic [31:0]      x_half_q,  x_half_d;
    logic [31:0]      y_seed_q,  y_seed_d;
    class_e           special_q, special_d;
    logic [TAG_W-1:0] tag_q,     tag_d;

    class_e    in_class;
    logic [7:0] s1_e;

    // Zero (incl. denormals) is tested before sign so -0 is zero; NaN outranks everything.
    always_comb begin
        in_class = CLS_NORMAL;
        if (Data_in[30:23] == 8'hFF && Data_in[22:0] != 23'd0) begin
            in_class = CLS_NAN;
        end else if (Data_in[30:23] == 8'h00) begin
            in_class = CLS_ZERO;
        end else if (Data_in[31]) begin
            in_class = CLS_NEG;
        end else if (Data_in[30:23] == 8'hFF) begin
            in_class = CLS_PINF;
        end
    end

    // NOTE: every always_comb output gets a hold/default value first so no latch is inferred.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s1_class_d = s1_class_q;
        if (ce) begin
            s1_valid_d = In_valid;
            s1_data_d  = Data_in;
            s1_tag_d   = Tag_in;
            s1_class_d = in_class;
        end
    end

    assign s1_e = s1_data_q[30:23];

    always_comb begin
        valid_d   = valid_q;
        x_half_d  = x_half_q;
        y_seed_d  = y_seed_q;
        special_d = special_q;
        tag_d     = tag_q;
        if (ce) begin
            valid_d   = s1_valid_q;
            special_d = s1_valid_q ? s1_class_q : CLS_NORMAL;
            tag_d     = s1_valid_q ? s1_tag_q : '0;
            x_half_d  = '0;
            y_seed_d  = '0;
            if (s1_class_q == CLS_NORMAL) begin
                // Halving the smallest normal exponent lands in the denormal range.
                if (s1_e == 8'd1) begin
                    x_half_d = {1'b0, 8'h00, 1'b1, s1_data_q[22:1]};
                end else begin
                    x_half_d = {1'b0, s1_e - 8'd1, s1_data_q[22:0]};
                end
                y_seed_d = MAGIC - {1'b0, s1_data_q[31:1]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_class_q <= CLS_NORMAL;
            valid_q    <= 1'b0;
            x_half_q   <= '0;
            y_seed_q   <= '0;
            special_q  <= CLS_NORMAL;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_class_q <= s1_class_d;
            valid_q    <= valid_d;
            x_half_q   <= x_half_d;
            y_seed_q   <= y_seed_d;
            special_q  <= special_d;
            tag_q      <= tag_d;
        end
    end

    assign X_half  = x_half_q;
    assign Y_seed  = y_seed_q;
    assign Special = special_q;
    assign Tag_out = tag_q;
    assign Valid   = valid_q;

`ifdef FISR_SEED_STATS_EN
    logic [15:0] special_cnt_q, special_cnt_d;

    // Counts operands entering stage 2 with a non-normal class; clear beats increment.
    always_comb begin
        special_cnt_d = special_cnt_q;
        if (ce) begin
            if (Stats_clr) begin
                special_cnt_d = '0;
            end else if (s1_valid_q && s1_class_q != CLS_NORMAL && special_cnt_q != 16'hFFFF) begin
                special_cnt_d = special_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            special_cnt_q <= '0;
        end else begin
            special_cnt_q <= special_cnt_d;
        end
    end

    assign Special_cnt = special_cnt_q;
`endif

endmodule
